// File: rtl/mc14500b_sequencer.sv
// Program sequencer for the MC14500B ICU: fetches words from a synchronous ROM,
// strobes opcodes to the ICU and executes JMP/RTN/SKZ/NOPO/NOPF flow control itself.
module mc14500b_sequencer #(
   parameter int                ADDR_W        = 8,
   parameter logic [ADDR_W-1:0] START_ADDRESS = '0,
   parameter int                STACK_DEPTH   = 4,
   parameter bit                JMP_PUSH      = 1'b1,
   parameter bit                FLG0_HALT     = 1'b0,
   parameter bit                FLGF_LOOP     = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              RUN,
   output logic [ADDR_W-1:0] MEM_ADDR,
   input  logic [7:0]        MEM_DATA,
   input  logic              RR,
   output logic [3:0]        INSTR,
   output logic [3:0]        IO_ADDR,
   output logic              INSTR_VALID,
   output logic [ADDR_W-1:0] PC,
   output logic              HALTED,
   output logic              STACK_ERR
);

   localparam int SP_W = $clog2(STACK_DEPTH + 1);

   localparam logic [3:0] OP_NOPO = 4'h0;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_RTN  = 4'hD;
   localparam logic [3:0] OP_SKZ  = 4'hE;
   localparam logic [3:0] OP_NOPF = 4'hF;

   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] TWO     = ADDR_W'(2);
   localparam logic [SP_W-1:0]   SP_ONE  = SP_W'(1);
   localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);

   typedef enum logic [1:0] {
      S_FETCH,
      S_EXEC,
      S_JMP_TGT,
      S_HALT
   } state_t;

   state_t            state, state_d;
   logic [ADDR_W-1:0] pc, pc_d;
   logic [ADDR_W-1:0] mem_addr, mem_addr_d;
   logic [SP_W-1:0]   sp, sp_d;
   logic              skip_pending, skip_d;
   logic [3:0]        instr, instr_d;
   logic [3:0]        io_addr, io_d;
   logic              valid, valid_d;
   logic              stack_err, err_d;
   logic [3:0]        jmp_io, jmp_io_d;
   logic              push_en;
   logic [ADDR_W-1:0] push_val;

   logic [ADDR_W-1:0] stack [2**SP_W];

   logic [3:0]        opcode;
   logic [3:0]        operand;
   logic [ADDR_W-1:0] target;

   assign opcode  = MEM_DATA[7:4];
   assign operand = MEM_DATA[3:0];
   assign target  = ADDR_W'(MEM_DATA);

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d    = state;
      pc_d       = pc;
      mem_addr_d = mem_addr;
      sp_d       = sp;
      skip_d     = skip_pending;
      instr_d    = instr;
      io_d       = io_addr;
      valid_d    = 1'b0;
      err_d      = stack_err;
      jmp_io_d   = jmp_io;
      push_en    = 1'b0;
      push_val   = pc + TWO;

      unique case (state)
         S_FETCH: begin
            if (RUN) begin
               state_d    = S_EXEC;
               // Prefetch the next word so a JMP target is on MEM_DATA one cycle after EXEC.
               mem_addr_d = pc + ONE;
            end
         end

         S_EXEC: begin
            state_d = S_FETCH;
            if (skip_pending) begin
               skip_d = 1'b0;
               pc_d   = (opcode == OP_JMP) ? pc + TWO : pc + ONE;
            end else if (opcode == OP_JMP) begin
               state_d  = S_JMP_TGT;
               jmp_io_d = operand;
            end else begin
               valid_d = 1'b1;
               instr_d = opcode;
               io_d    = operand;
               pc_d    = pc + ONE;
               unique case (opcode)
                  OP_RTN: begin
                     if (sp != '0) begin
                        sp_d = sp - SP_ONE;
                        pc_d = stack[sp - SP_ONE];
                     end else begin
                        pc_d = START_ADDRESS;
                     end
                  end
                  OP_SKZ:  skip_d = ~RR;
                  OP_NOPO: begin
                     if (FLG0_HALT) begin
                        state_d = S_HALT;
                        pc_d    = pc;
                     end
                  end
                  OP_NOPF: if (FLGF_LOOP) pc_d = START_ADDRESS;
                  default: ;
               endcase
            end
            if (state_d != S_JMP_TGT) mem_addr_d = pc_d;
         end

         S_JMP_TGT: begin
            valid_d = 1'b1;
            instr_d = OP_JMP;
            io_d    = jmp_io;
            if (JMP_PUSH) begin
               if (sp != SP_FULL) begin
                  push_en = 1'b1;
                  sp_d    = sp + SP_ONE;
               end else begin
                  err_d = 1'b1;
               end
            end
            pc_d       = target;
            mem_addr_d = target;
            state_d    = S_FETCH;
         end

         S_HALT: ;

         default: state_d = S_FETCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state        <= S_FETCH;
         pc           <= START_ADDRESS;
         mem_addr     <= START_ADDRESS;
         sp           <= '0;
         skip_pending <= 1'b0;
         instr        <= 4'h0;
         io_addr      <= 4'h0;
         valid        <= 1'b0;
         stack_err    <= 1'b0;
         jmp_io       <= 4'h0;
      end else begin
         state        <= state_d;
         pc           <= pc_d;
         mem_addr     <= mem_addr_d;
         sp           <= sp_d;
         skip_pending <= skip_d;
         instr        <= instr_d;
         io_addr      <= io_d;
         valid        <= valid_d;
         stack_err    <= err_d;
         jmp_io       <= jmp_io_d;
      end
   end

   // NOTE: stack storage is not reset; entries are only read below sp, which reset clears.
   always_ff @(posedge CLK) begin
      if (push_en) stack[sp] <= push_val;
   end

   assign MEM_ADDR    = mem_addr;
   assign INSTR       = instr;
   assign IO_ADDR     = io_addr;
   assign INSTR_VALID = valid;
   assign PC          = pc;
   assign HALTED      = (state == S_HALT);
   assign STACK_ERR   = stack_err;

endmodule

// File: tb/tb_mc14500b_sequencer.sv
// Self-checking bench for mc14500b_sequencer: directed and random programs compared
// against an instruction-level reference model of the sequencer.
module tb_mc14500b_sequencer;

   logic       clk, rst, run, rr;
   logic [7:0] mem_addr, mem_data, pc;
   logic [3:0] instr, io_addr;
   logic       instr_valid, halted, stack_err;

   logic [7:0] rom [256];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   typedef struct {
      int         cyc;
      logic [3:0] instr;
      logic [3:0] io;
      logic [7:0] pc;
      logic [7:0] prev_pc;
      logic       err;
   } obs_t;

   typedef struct {
      int         cyc;
      logic [3:0] instr;
      logic [3:0] io;
      logic [7:0] at;
      logic [7:0] nxt;
      logic       err;
      bit         jmp;
   } exp_t;

   obs_t       obs[$];
   exp_t       exp_q[$];
   logic [7:0] prev_pc = 8'h00;

   mc14500b_sequencer #(
      .ADDR_W(8), .START_ADDRESS(8'h00), .STACK_DEPTH(4),
      .JMP_PUSH(1'b1), .FLG0_HALT(1'b1), .FLGF_LOOP(1'b1)
   ) dut (
      .CLK(clk), .RST(rst), .RUN(run),
      .MEM_ADDR(mem_addr), .MEM_DATA(mem_data), .RR(rr),
      .INSTR(instr), .IO_ADDR(io_addr), .INSTR_VALID(instr_valid),
      .PC(pc), .HALTED(halted), .STACK_ERR(stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) mem_data <= rom[mem_addr];

   always @(negedge clk) begin
      if (rst && instr_valid)
         obs.push_back('{cyc, instr, io_addr, pc, prev_pc, stack_err});
      prev_pc <= pc;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill_rom(input logic [7:0] w);
      for (int i = 0; i < 256; i++) rom[i] = w;
   endtask

   // Instruction-level model: walks the program and lists every expected strobe.
   task automatic build_model(input logic rr_v, input int max_ev, output bit halts);
      logic [7:0] p;
      logic [7:0] w;
      logic [3:0] op;
      logic [7:0] stk[$];
      bit         skip;
      bit         err;
      int         t;
      exp_t       e;
      p = 8'h00; skip = 0; err = 0; t = 0; halts = 0;
      exp_q.delete();
      while (exp_q.size() < max_ev) begin
         w  = rom[p];
         op = w[7:4];
         if (skip) begin
            skip = 0;
            p    = (op == 4'hC) ? p + 8'd2 : p + 8'd1;
            t    = t + 2;
            continue;
         end
         e.at = p; e.instr = op; e.io = w[3:0]; e.jmp = (op == 4'hC);
         if (op == 4'hC) begin
            t = t + 3;
            if (stk.size() < 4) stk.push_back(p + 8'd2);
            else err = 1;
            p = rom[p + 8'd1];
         end else begin
            t = t + 2;
            case (op)
               4'hD:    p = (stk.size() > 0) ? stk.pop_back() : 8'h00;
               4'hE:    begin skip = !rr_v; p = p + 8'd1; end
               4'h0:    halts = 1;
               4'hF:    p = 8'h00;
               default: p = p + 8'd1;
            endcase
         end
         e.cyc = t; e.nxt = p; e.err = err;
         exp_q.push_back(e);
         if (halts) break;
      end
   endtask

   task automatic run_prog(input string name, input logic rr_v, input int max_ev);
      bit         halts;
      int         base, start, budget, k;
      logic [7:0] held_addr;
      @(negedge clk);
      rst = 1'b0; run = 1'b1; rr = rr_v;
      repeat (2) @(negedge clk);
      check({name, " rst pc"}, pc, 8'h00);
      check({name, " rst stack_err"}, stack_err, 1'b0);
      check({name, " rst halted"}, halted, 1'b0);
      build_model(rr_v, max_ev, halts);
      rst   = 1'b1;
      base  = cyc;
      start = obs.size();
      budget = 6 * max_ev + 20;
      for (int i = 0; i < budget; i++) begin
         if (obs.size() - start >= exp_q.size()) break;
         @(negedge clk);
      end
      check({name, " strobes seen"}, (obs.size() - start >= exp_q.size()), 1'b1);
      for (int i = 0; i < exp_q.size(); i++) begin
         k = start + i;
         if (k >= obs.size()) break;
         check($sformatf("%s[%0d] cycle", name, i), obs[k].cyc - base, exp_q[i].cyc);
         check($sformatf("%s[%0d] instr", name, i), obs[k].instr, exp_q[i].instr);
         if (!exp_q[i].jmp)
            check($sformatf("%s[%0d] io", name, i), obs[k].io, exp_q[i].io);
         check($sformatf("%s[%0d] exec pc", name, i), obs[k].prev_pc, exp_q[i].at);
         check($sformatf("%s[%0d] next pc", name, i), obs[k].pc, exp_q[i].nxt);
         check($sformatf("%s[%0d] stack_err", name, i), obs[k].err, exp_q[i].err);
      end
      if (halts) begin
         held_addr = mem_addr;
         repeat (8) @(negedge clk);
         check({name, " no strobe after halt"}, obs.size() - start, exp_q.size());
         check({name, " halted"}, halted, 1'b1);
         check({name, " mem_addr held"}, mem_addr, held_addr);
      end
   endtask

   initial begin
      logic [7:0] w;
      rst = 1'b0; run = 1'b0; rr = 1'b0;
      fill_rom(8'h31);
      repeat (2) @(negedge clk);
      check("reset mem_addr", mem_addr, 8'h00);
      check("reset pc", pc, 8'h00);
      check("reset instr", instr, 4'h0);
      check("reset io_addr", io_addr, 4'h0);
      check("reset valid", instr_valid, 1'b0);
      check("reset halted", halted, 1'b0);
      check("reset stack_err", stack_err, 1'b0);

      // RUN low: sequencer waits in FETCH.
      begin
         int n0;
         rst = 1'b1;
         n0 = obs.size();
         repeat (5) begin
            @(negedge clk);
            check("stall pc", pc, 8'h00);
            check("stall mem_addr", mem_addr, 8'h00);
         end
         check("stall strobes", obs.size() - n0, 0);
      end

      // Straight-line code ending in a halting NOPO, then async reset mid-halt.
      fill_rom(8'h31);
      rom[0] = 8'h13; rom[1] = 8'h85; rom[2] = 8'h13; rom[3] = 8'h00;
      run_prog("halt", 1'b0, 10);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("async rst pc", pc, 8'h00);
      check("async rst halted", halted, 1'b0);
      check("async rst valid", instr_valid, 1'b0);
      check("async rst mem_addr", mem_addr, 8'h00);

      // Call and return.
      fill_rom(8'h31);
      rom[0] = 8'hC0; rom[1] = 8'h10; rom[8'h10] = 8'hD0;
      run_prog("call", 1'b0, 6);

      // SKZ over a JMP, with RR low (skip) and high (no skip).
      fill_rom(8'h31);
      rom[0] = 8'hE0; rom[1] = 8'hC0; rom[2] = 8'h20; rom[3] = 8'h11; rom[8'h20] = 8'h15;
      run_prog("skz0", 1'b0, 5);
      run_prog("skz1", 1'b1, 5);

      // Nested calls overflow the 4-deep stack, then unwind past empty.
      fill_rom(8'h31);
      rom[8'h00] = 8'hC0; rom[8'h01] = 8'h10;
      rom[8'h10] = 8'hC1; rom[8'h11] = 8'h20;
      rom[8'h20] = 8'hC2; rom[8'h21] = 8'h30;
      rom[8'h30] = 8'hC3; rom[8'h31] = 8'h40;
      rom[8'h40] = 8'hC4; rom[8'h41] = 8'h50;
      rom[8'h50] = 8'hD0; rom[8'h32] = 8'hD1; rom[8'h22] = 8'hD2;
      rom[8'h12] = 8'hD3; rom[8'h02] = 8'hD4;
      run_prog("nest", 1'b0, 16);

      // JMP at the last address fetches its target from address 0.
      fill_rom(8'h31);
      rom[8'h00] = 8'hC0; rom[8'h01] = 8'hFF; rom[8'hFF] = 8'hC7;
      run_prog("wrap", 1'b0, 8);

      // Random programs; NOPO kept rare so runs mostly go the full length.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 256; i++) begin
            w = 8'($urandom);
            if (w[7:4] == 4'h0 && $urandom_range(0, 7) != 0) w[7:4] = 4'h2;
            rom[i] = w;
         end
         run_prog($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 40);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
